// File: rtl/sw_debounce_capture_pkg.sv
// Shared constants and types for the slide-switch debounce/capture stage.
// Board and simulation debounce lengths live here so benches and top agree.
package sw_debounce_capture_pkg;

    localparam int unsigned SW_WIDTH_DEF   = 8;
    localparam int unsigned DEBOUNCE_BOARD = 1_000_000;
    localparam int unsigned DEBOUNCE_SIM   = 4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    // Counter width for a given debounce length; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sw_debounce_capture_if.sv
// Change-record handshake: producer offers mask/overrun under valid, consumer
// accepts with ready.
interface sw_debounce_capture_if #(
    parameter int unsigned WIDTH = 8
);
    logic             chg_valid;
    logic [WIDTH-1:0] chg_mask;
    logic             chg_overrun;
    logic             chg_ready;

    modport master (
        output chg_valid,
        output chg_mask,
        output chg_overrun,
        input  chg_ready
    );

    modport slave (
        input  chg_valid,
        input  chg_mask,
        input  chg_overrun,
        output chg_ready
    );
endinterface

// File: rtl/sw_debounce_capture_debounce_bit.sv
// One switch bit: 2-FF synchroniser, consecutive-cycle debounce counter and
// registered rise/fall pulses on each accepted change.
module sw_debounce_bit
    import sw_debounce_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             fall_q;
    edge_e            edge_d;

    // Any return to the stable level clears the count: no partial credit.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        edge_d   = EDGE_NONE;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = sync2_q;
            edge_d   = sync2_q ? EDGE_RISE : EDGE_FALL;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= (edge_d == EDGE_RISE);
            fall_q   <= (edge_d == EDGE_FALL);
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/sw_debounce_capture.sv
// Slide-switch input stage: per-bit sync/debounce driving led, edge pulses,
// and a latched change mask offered over a valid/ready handshake.
module sw_debounce_capture
    import sw_debounce_capture_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_BOARD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          sw,
    output logic [WIDTH-1:0]          led,
    output logic [WIDTH-1:0]          sw_rise,
    output logic [WIDTH-1:0]          sw_fall,
    sw_debounce_capture_if.master     chg
);

    logic [WIDTH-1:0] flip;
    logic             take;
    logic [WIDTH-1:0] mask_keep;
    logic             ovr_keep;
    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic             ovr_q;
    logic             ovr_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (sw[i]),
            .stable (led[i]),
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i])
        );
    end

    // A take in the same cycle as new flips retires the old record first, so
    // the new flips start a fresh record instead of counting as overrun.
    always_comb begin
        flip      = sw_rise | sw_fall;
        take      = valid_q & chg.chg_ready;
        mask_keep = take ? '0 : mask_q;
        ovr_keep  = take ? 1'b0 : ovr_q;
        mask_d    = mask_keep | flip;
        valid_d   = |mask_d;
        ovr_d     = ovr_keep | (|(flip & mask_keep));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mask_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            mask_q  <= mask_d;
            ovr_q   <= ovr_d;
        end
    end

    assign chg.chg_valid   = valid_q;
    assign chg.chg_mask    = mask_q;
    assign chg.chg_overrun = ovr_q;

endmodule

// File: tb/tb_sw_debounce_capture.sv
// Directed bench for sw_debounce_capture with WIDTH=8, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sw_debounce_capture;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic [7:0] led;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;

    int unsigned n_cmp;
    int unsigned n_err;

    sw_debounce_capture_if #(.WIDTH(8)) chg_if ();

    sw_debounce_capture #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .led     (led),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .chg     (chg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic take_record();
        chg_if.chg_ready = 1'b1;
        tick(1);
        chg_if.chg_ready = 1'b0;
        check("take_valid", 32'(chg_if.chg_valid), 32'h0);
        check("take_mask", 32'(chg_if.chg_mask), 32'h00);
        check("take_ovr", 32'(chg_if.chg_overrun), 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        sw = 8'hFF;
        chg_if.chg_ready = 1'b0;

        // 1: reset, then all-ones accepted 6 edges after release
        tick(3);
        check("rst_led", 32'(led), 32'h00);
        check("rst_valid", 32'(chg_if.chg_valid), 32'h0);
        check("rst_rise", 32'(sw_rise), 32'h00);
        rst_n = 1'b1;
        tick(5);
        check("t1_led_early", 32'(led), 32'h00);
        tick(1);
        check("t1_led", 32'(led), 32'hFF);
        check("t1_rise", 32'(sw_rise), 32'hFF);
        check("t1_valid_lag", 32'(chg_if.chg_valid), 32'h0);
        tick(1);
        check("t1_rise_end", 32'(sw_rise), 32'h00);
        check("t1_valid", 32'(chg_if.chg_valid), 32'h1);
        check("t1_mask", 32'(chg_if.chg_mask), 32'hFF);
        check("t1_ovr", 32'(chg_if.chg_overrun), 32'h0);
        take_record();

        sw = 8'h00;
        tick(6);
        check("clr_led", 32'(led), 32'h00);
        check("clr_fall", 32'(sw_fall), 32'hFF);
        tick(1);
        check("clr_mask", 32'(chg_if.chg_mask), 32'hFF);
        take_record();

        // 2: three-cycle glitch is rejected; a four-cycle hold is accepted
        sw = 8'h01;
        tick(3);
        sw = 8'h00;
        for (int unsigned k = 0; k < 10; k++) begin
            tick(1);
            check("t2_glitch_led", 32'(led), 32'h00);
            check("t2_glitch_rise", 32'(sw_rise), 32'h00);
            check("t2_glitch_valid", 32'(chg_if.chg_valid), 32'h0);
        end
        sw = 8'h01;
        tick(5);
        check("t2_led_early", 32'(led), 32'h00);
        tick(1);
        check("t2_led", 32'(led), 32'h01);
        check("t2_rise", 32'(sw_rise), 32'h01);
        tick(1);
        check("t2_valid", 32'(chg_if.chg_valid), 32'h1);
        check("t2_mask", 32'(chg_if.chg_mask), 32'h01);
        take_record();

        // 3: record held while ready is low
        sw = 8'h09;
        tick(7);
        for (int unsigned k = 0; k < 20; k++) begin
            check("t3_hold_valid", 32'(chg_if.chg_valid), 32'h1);
            check("t3_hold_mask", 32'(chg_if.chg_mask), 32'h08);
            tick(1);
        end
        take_record();

        // 4: new flip coincides with the take of the old record
        sw = 8'h01;
        tick(7);
        check("t4_old_mask", 32'(chg_if.chg_mask), 32'h08);
        sw = 8'h21;
        tick(6);
        check("t4_rise", 32'(sw_rise), 32'h20);
        check("t4_pre_valid", 32'(chg_if.chg_valid), 32'h1);
        check("t4_pre_mask", 32'(chg_if.chg_mask), 32'h08);
        chg_if.chg_ready = 1'b1;
        tick(1);
        chg_if.chg_ready = 1'b0;
        check("t4_valid", 32'(chg_if.chg_valid), 32'h1);
        check("t4_mask", 32'(chg_if.chg_mask), 32'h20);
        check("t4_ovr", 32'(chg_if.chg_overrun), 32'h0);
        take_record();

        // 5: same bit flips twice before the record is taken
        sw = 8'h25;
        tick(7);
        check("t5_first_mask", 32'(chg_if.chg_mask), 32'h04);
        check("t5_first_ovr", 32'(chg_if.chg_overrun), 32'h0);
        sw = 8'h21;
        tick(7);
        check("t5_valid", 32'(chg_if.chg_valid), 32'h1);
        check("t5_mask", 32'(chg_if.chg_mask), 32'h04);
        check("t5_ovr", 32'(chg_if.chg_overrun), 32'h1);
        take_record();

        // 6: reset during count 2 of a sw[7] change discards the count
        sw = 8'hA1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_led", 32'(led), 32'h00);
        check("t6_rst_rise", 32'(sw_rise), 32'h00);
        check("t6_rst_fall", 32'(sw_fall), 32'h00);
        check("t6_rst_valid", 32'(chg_if.chg_valid), 32'h0);
        check("t6_rst_mask", 32'(chg_if.chg_mask), 32'h00);
        check("t6_rst_ovr", 32'(chg_if.chg_overrun), 32'h0);
        rst_n = 1'b1;
        tick(5);
        check("t6_led_early", 32'(led), 32'h00);
        tick(1);
        check("t6_led", 32'(led), 32'hA1);
        check("t6_rise", 32'(sw_rise), 32'hA1);
        tick(1);
        check("t6_valid", 32'(chg_if.chg_valid), 32'h1);
        check("t6_mask", 32'(chg_if.chg_mask), 32'hA1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
